pll_clk_rst_seq: RTL and testbench

- Parametrised successor to the two-output PLL wrapper. It runs on the PLL output clock and converts it into NUM_CH divided clock-enable channels.
- Qualifies the PLL lock, releases per-channel resets in staggered order, and re-sequences automatically on loss of lock.
- Sits between the PLL instance and the processing domains (WiMax TX/RX chains). It replaces ad-hoc per-domain clocks with enables on one clock.

---
 rtl/clkrst_pkg.sv | 25 ++
 rtl/clk_en_div.sv | 33 +++
 rtl/pll_clk_rst_seq.sv | 143 ++++++++++++++
 tb/tb_pll_clk_rst_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkrst_pkg.sv
// Shared types and sizing helpers for the PLL clock/reset sequencer.
// Holds the sequencer state encoding and the counter width calculation.
package clkrst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } seq_state_t;

    // One counter serves the filter, hold and stagger phases, so it must cover the longest one.
    function automatic int cnt_width(input int lock_filt, input int rst_hold,
                                     input int stagger, input int num_ch);
        int span;
        span = lock_filt;
        if (rst_hold > span) span = rst_hold;
        if (stagger * (num_ch - 1) + 1 > span) span = stagger * (num_ch - 1) + 1;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

    localparam int CNT_W = cnt_width(16, 8, 4, 4);

endpackage

// File: rtl/clk_en_div.sv
// Single-channel clock-enable divider: one ce pulse every ratio cycles while run is high.
// The ratio is latched at the start of each period so mid-period changes wait for the next one.
module clk_en_div #(
    parameter int DIV_W = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] ratio,
    output logic             ce
);

    logic [DIV_W-1:0] dcnt;
    logic [DIV_W-1:0] dr;
    logic             wrap;

    // Ratios of 0 and 1 both mean "every cycle"; the guard also keeps dr-1 from underflowing.
    assign wrap = (dr <= DIV_W'(1)) || (dcnt == dr - DIV_W'(1));
    assign ce   = run & wrap;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            dcnt <= '0;
            dr   <= '0;
        end else if (!run || wrap) begin
            dcnt <= '0;
            dr   <= ratio;
        end else begin
            dcnt <= dcnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pll_clk_rst_seq.sv
// Qualifies PLL lock, releases per-channel resets in staggered order and drives
// per-channel clock enables on the single PLL output clock.
module pll_clk_rst_seq
    import clkrst_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int LOCK_FILT = 16,
    parameter int RST_HOLD  = 8,
    parameter int STAGGER   = 4
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    lock_lost_clr,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic                    sys_ready,
    output logic                    lock_lost,
    output logic [2:0]              seq_state
);

    localparam int CW       = cnt_width(LOCK_FILT, RST_HOLD, STAGGER, NUM_CH);
    localparam int REL_LAST = STAGGER * (NUM_CH - 1);

    logic              lock_meta;
    logic              lock_s;
    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [NUM_CH-1:0] rst_n_nxt;
    logic              ready_nxt;
    logic              lost_nxt;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            ch_rst_n  <= '0;
            sys_ready <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ch_rst_n  <= rst_n_nxt;
            sys_ready <= ready_nxt;
            lock_lost <= lost_nxt;
        end
    end

    // Loss of lock outranks every phase; released channels all drop together.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rst_n_nxt = ch_rst_n;
        ready_nxt = sys_ready;
        lost_nxt  = lock_lost_clr ? 1'b0 : lock_lost;

        if (!lock_s && state != WAIT_LOCK) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
            rst_n_nxt = '0;
            ready_nxt = 1'b0;
            if (state == RUN) lost_nxt = 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = FILTER;
                        cnt_nxt   = '0;
                    end
                end
                FILTER: begin
                    if (cnt == CW'(LOCK_FILT - 1)) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == CW'(RST_HOLD - 1)) begin
                        cnt_nxt      = '0;
                        rst_n_nxt[0] = 1'b1;
                        if (NUM_CH == 1) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    cnt_nxt = cnt + CW'(1);
                    for (int i = 1; i < NUM_CH; i++) begin
                        if (cnt_nxt == CW'(STAGGER * i)) rst_n_nxt[i] = 1'b1;
                    end
                    if (cnt_nxt == CW'(REL_LAST)) begin
                        state_nxt = RUN;
                        ready_nxt = 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    rst_n_nxt = '0;
                    ready_nxt = 1'b0;
                end
            endcase
        end
    end

    assign seq_state = state;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_div
        clk_en_div #(
            .DIV_W (DIV_W)
        ) u_div (
            .refclk (refclk),
            .rst    (rst),
            .run    (ch_rst_n[g]),
            .ratio  (div_ratio[g*DIV_W +: DIV_W]),
            .ce     (ce[g])
        );
    end

endmodule

// File: tb/tb_pll_clk_rst_seq.sv
// Self-checking bench for pll_clk_rst_seq: directed steps plus random stimulus,
// checked against a run-length/event-time reference model.
module tb_pll_clk_rst_seq;

    localparam int NC = 4;
    localparam int DW = 8;
    localparam int LF = 16;
    localparam int RH = 8;
    localparam int ST = 4;
    localparam int RUN_THR = LF + RH + 1 + ST * (NC - 1);

    logic             refclk = 1'b0;
    logic             rst;
    logic             pll_locked;
    logic [NC*DW-1:0] div_ratio;
    logic             lock_lost_clr;
    logic [NC-1:0]    ce;
    logic [NC-1:0]    ch_rst_n;
    logic             sys_ready;
    logic             lock_lost;
    logic [2:0]       seq_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: c counts consecutive edges at which the synchronised lock was high.
    bit          lockq[$];
    int          c;
    int          now;
    bit          m_lost;
    bit [NC-1:0] m_rel;
    bit [NC-1:0] m_ce;
    int          next_ce[NC];

    pll_clk_rst_seq #(
        .NUM_CH    (NC),
        .DIV_W     (DW),
        .LOCK_FILT (LF),
        .RST_HOLD  (RH),
        .STAGGER   (ST)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .div_ratio     (div_ratio),
        .lock_lost_clr (lock_lost_clr),
        .ce            (ce),
        .ch_rst_n      (ch_rst_n),
        .sys_ready     (sys_ready),
        .lock_lost     (lock_lost),
        .seq_state     (seq_state)
    );

    always #5 refclk = ~refclk;

    function automatic int rel_thr(input int i);
        return LF + RH + 1 + ST * i;
    endfunction

    function automatic logic [2:0] exp_state(input int cc);
        if (cc == 0) return 3'd0;
        if (cc <= LF) return 3'd1;
        if (cc <= LF + RH) return 3'd2;
        if (cc < RUN_THR) return 3'd3;
        return 3'd4;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        lockq.delete();
        c      = 0;
        now    = 0;
        m_lost = 1'b0;
        m_rel  = '0;
        m_ce   = '0;
        for (int i = 0; i < NC; i++) next_ce[i] = 0;
    endtask

    task automatic model_edge();
        bit ls;
        bit newrel;
        int r;
        int per;
        ls = (lockq.size() == 2) ? lockq[0] : 1'b0;
        lockq.push_back(pll_locked);
        if (lockq.size() > 2) void'(lockq.pop_front());
        if (!ls && c >= RUN_THR) m_lost = 1'b1;
        else if (lock_lost_clr) m_lost = 1'b0;
        c = ls ? c + 1 : 0;
        now++;
        for (int i = 0; i < NC; i++) begin
            newrel = (c >= rel_thr(i));
            r      = int'(div_ratio[i*DW +: DW]);
            per    = (r < 2) ? 1 : r;
            if (newrel && (!m_rel[i] || m_ce[i])) next_ce[i] = now + per - 1;
            m_rel[i] = newrel;
            m_ce[i]  = newrel && (now == next_ce[i]);
        end
    endtask

    task automatic check_all();
        check_output("ch_rst_n", ch_rst_n, m_rel);
        check_output("ce", ce, m_ce);
        check_output("sys_ready", sys_ready, c >= RUN_THR);
        check_output("lock_lost", lock_lost, m_lost);
        check_output("seq_state", seq_state, exp_state(c));
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        check_all();
    endtask

    task automatic apply_stimulus(input int ticks, input bit rnd_lock);
        for (int t = 0; t < ticks; t++) begin
            if (($urandom % 10) == 0)
                div_ratio[($urandom % NC)*DW +: DW] = (($urandom % 40) == 0) ? 8'd255 : 8'($urandom_range(0, 9));
            lock_lost_clr = (($urandom % 20) == 0);
            if (rnd_lock && (($urandom % 120) == 0)) begin
                pll_locked = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                pll_locked = 1'b1;
            end
            tick();
        end
        lock_lost_clr = 1'b0;
    endtask

    initial begin
        int guard;
        rst           = 1'b0;
        pll_locked    = 1'b0;
        lock_lost_clr = 1'b0;
        div_ratio     = {8'd1, 8'd2, 8'd3, 8'd5};
        model_reset();
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        check_all();
        check_output("reset_ch_rst_n", ch_rst_n, 4'b0000);
        rst = 1'b1;

        // Clean lock: edge 0 is the first edge with pll_locked high.
        repeat (3) tick();
        pll_locked = 1'b1;
        for (int e = 0; e <= 45; e++) begin
            tick();
            if (e == 25) check_output("rel_e25", ch_rst_n, 4'b0000);
            if (e == 26) check_output("rel_e26", ch_rst_n, 4'b0001);
            if (e == 29) check_output("ce0_e29", ce[0], 1'b0);
            if (e == 30) check_output("rel_e30", ch_rst_n, 4'b0011);
            if (e == 30) check_output("ce0_e30", ce[0], 1'b1);
            if (e == 34) check_output("rel_e34", ch_rst_n, 4'b0111);
            if (e == 37) check_output("ready_e37", sys_ready, 1'b0);
            if (e == 38) check_output("rel_e38", ch_rst_n, 4'b1111);
            if (e == 38) check_output("ready_e38", sys_ready, 1'b1);
        end

        // Ratio change on ch0 while its counter sits at 1.
        guard = 0;
        while ((next_ce[0] - now) != 3 && guard < 20) begin
            tick();
            guard++;
        end
        check_output("dcnt1_reached", guard < 20, 1'b1);
        div_ratio[7:0] = 8'd2;
        repeat (12) tick();

        apply_stimulus(60, 1'b0);

        // Loss of lock in RUN, then clear.
        pll_locked = 1'b0;
        repeat (3) tick();
        check_output("loss_ch_rst_n", ch_rst_n, 4'b0000);
        check_output("loss_flag", lock_lost, 1'b1);
        pll_locked    = 1'b1;
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        check_output("clr_flag", lock_lost, 1'b0);

        // Glitch during FILTER restarts the sequence from re-assertion.
        pll_locked = 1'b0;
        repeat (5) tick();
        pll_locked = 1'b1;
        for (int e = 0; e <= 60; e++) begin
            if (e == 10) pll_locked = 1'b0;
            if (e == 13) pll_locked = 1'b1;
            tick();
            if (e == 26) check_output("glitch_e26", ch_rst_n, 4'b0000);
            if (e == 38) check_output("glitch_e38", ch_rst_n[0], 1'b0);
            if (e == 39) check_output("glitch_e39", ch_rst_n[0], 1'b1);
        end

        // Clear coincident with a fresh loss: set wins.
        pll_locked = 1'b0;
        repeat (2) tick();
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        check_output("set_beats_clr", lock_lost, 1'b1);
        pll_locked = 1'b1;

        apply_stimulus(800, 1'b1);

        // Asynchronous reset mid-RELEASE, then a full clean sequence.
        pll_locked = 1'b0;
        repeat (4) tick();
        pll_locked = 1'b1;
        for (int e = 0; e <= 30; e++) tick();
        check_output("pre_rst_rel", ch_rst_n, 4'b0011);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check_output("async_ch_rst_n", ch_rst_n, 4'b0000);
        repeat (2) @(negedge refclk);
        rst = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            tick();
            if (e == 26) check_output("rerun_e26", ch_rst_n, 4'b0001);
            if (e == 38) check_output("rerun_e38", sys_ready, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
